correlator_window_acc: RTL and testbench

Downstream consumer of the correlator window dispatcher's one-cycle window strobe. Correlates a 1-bit sample stream against 1-bit I/Q reference phases. Accumulates signed ±1 products over each window. At every window boundary, dumps the I/Q sums and the sample count into a holding register, which the readout side drains over a valid/ready handshake.

---
 rtl/correlator_window_acc_pkg.sv | 17 +
 rtl/correlator_window_acc_sat_acc.sv | 46 ++++
 rtl/correlator_window_acc.sv | 128 ++++++++++++
 tb/tb_correlator_window_acc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/correlator_window_acc_pkg.sv
// Shared types and constants for the windowed 1-bit I/Q correlator.
package correlator_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Symmetric saturation magnitude for a signed accumulator of width w.
  function automatic int acc_pos_limit(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/correlator_window_acc_sat_acc.sv
// Signed +/-1 saturating accumulator with synchronous clear and
// restart (clear, then optionally take the first sample of a new window).
module corr_sat_acc
  import correlator_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                restart,
  input  logic                step,
  input  logic                up,
  output logic signed [W-1:0] acc
);

  localparam logic signed [W-1:0] POS_LIM = W'(acc_pos_limit(W));
  localparam logic signed [W-1:0] NEG_LIM = -POS_LIM;
  localparam logic signed [W-1:0] ONE     = W'(1);

  logic signed [W-1:0] acc_reg;
  logic signed [W-1:0] acc_next;
  logic signed [W-1:0] stepped;

  always_comb begin
    stepped = acc_reg;
    if (up) begin
      if (acc_reg != POS_LIM) stepped = acc_reg + ONE;
    end else begin
      if (acc_reg != NEG_LIM) stepped = acc_reg - ONE;
    end

    acc_next = acc_reg;
    if (clear)        acc_next = '0;
    else if (restart) acc_next = step ? (up ? ONE : -ONE) : '0;
    else if (step)    acc_next = stepped;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_reg <= '0;
    else        acc_reg <= acc_next;
  end

  assign acc = acc_reg;

endmodule

// File: rtl/correlator_window_acc.sv
// Window correlator: accumulates XNOR(+1)/XOR(-1) I/Q products between
// window strobes and dumps each completed window into a valid/ready holding register.
module correlator_window_acc
  import correlator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    win_stb,
  input  logic                    sample_valid,
  input  logic                    sample_in,
  input  logic                    ref_i,
  input  logic                    ref_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_i,
  output logic signed [ACC_W-1:0] out_q,
  output logic [CNT_W-1:0]        out_cnt,
  output logic                    overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_reg, state_next;
  logic clear, restart, step, dump;

  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;

  logic                    valid_reg;
  logic                    overrun_reg;
  logic signed [ACC_W-1:0] hold_i_reg, hold_q_reg;
  logic [CNT_W-1:0]        hold_cnt_reg;

  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    restart    = 1'b0;
    step       = 1'b0;
    dump       = 1'b0;
    if (!run) begin
      state_next = IDLE;
      clear      = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          clear = 1'b1;
          if (win_stb) state_next = ACCUM;
        end
        ACCUM: begin
          step = sample_valid;
          // A sample coinciding with the strobe seeds the new window.
          if (win_stb) begin
            dump    = 1'b1;
            restart = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  corr_sat_acc #(.W(ACC_W)) u_acc_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .restart (restart),
    .step    (step),
    .up      (sample_in ~^ ref_i),
    .acc     (acc_i)
  );

  corr_sat_acc #(.W(ACC_W)) u_acc_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .restart (restart),
    .step    (step),
    .up      (sample_in ~^ ref_q),
    .acc     (acc_q)
  );

  always_comb begin
    cnt_next = cnt_reg;
    if (clear)                             cnt_next = '0;
    else if (restart)                      cnt_next = CNT_W'(step);
    else if (step && (cnt_reg != CNT_MAX)) cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  // Holding register: a dump always wins; it is an overrun only if the old result is not leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      overrun_reg  <= 1'b0;
      hold_i_reg   <= '0;
      hold_q_reg   <= '0;
      hold_cnt_reg <= '0;
    end else if (dump) begin
      valid_reg    <= 1'b1;
      hold_i_reg   <= acc_i;
      hold_q_reg   <= acc_q;
      hold_cnt_reg <= cnt_reg;
      if (valid_reg && !out_ready) overrun_reg <= 1'b1;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_i     = hold_i_reg;
  assign out_q     = hold_q_reg;
  assign out_cnt   = hold_cnt_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_correlator_window_acc.sv
// Self-checking bench: table vectors, directed window sequences and
// randomized traffic against a queue-based window model (16-bit and 8-bit DUTs).
module tb_correlator_window_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, run, win_stb, sample_valid, sample_in, ref_i, ref_q, out_ready;

  logic               v16, ovr16, v8, ovr8;
  logic signed [15:0] i16, q16;
  logic [15:0]        c16, c8;
  logic signed [7:0]  i8, q8;

  correlator_window_acc #(.ACC_W(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .run(run), .win_stb(win_stb),
    .sample_valid(sample_valid), .sample_in(sample_in), .ref_i(ref_i), .ref_q(ref_q),
    .out_valid(v16), .out_ready(out_ready), .out_i(i16), .out_q(q16),
    .out_cnt(c16), .overrun(ovr16)
  );

  correlator_window_acc #(.ACC_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .run(run), .win_stb(win_stb),
    .sample_valid(sample_valid), .sample_in(sample_in), .ref_i(ref_i), .ref_q(ref_q),
    .out_valid(v8), .out_ready(out_ready), .out_i(i8), .out_q(q8),
    .out_cnt(c8), .overrun(ovr8)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current window kept as a list of +/-1 products.
  bit m_in_win, m_valid, m_ovr;
  int m_i16, m_q16, m_i8, m_q8, m_cnt;
  int win_pi[$];
  int win_pq[$];

  function automatic int sat_fold(input int prods[$], input int lim);
    int s;
    s = 0;
    foreach (prods[k]) begin
      s = s + prods[k];
      if (s > lim)  s = lim;
      if (s < -lim) s = -lim;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_in_win = 0; m_valid = 0; m_ovr = 0;
    m_i16 = 0; m_q16 = 0; m_i8 = 0; m_q8 = 0; m_cnt = 0;
    win_pi.delete(); win_pq.delete();
  endtask

  task automatic model_step();
    bit xfer, dmp;
    xfer = m_valid && out_ready;
    dmp  = run && m_in_win && win_stb;
    if (xfer) $display("xfer: i=%0d q=%0d cnt=%0d", m_i16, m_q16, m_cnt);
    if (dmp) begin
      if (m_valid && !out_ready) m_ovr = 1;
      m_i16 = sat_fold(win_pi, 32767);
      m_q16 = sat_fold(win_pq, 32767);
      m_i8  = sat_fold(win_pi, 127);
      m_q8  = sat_fold(win_pq, 127);
      m_cnt = (win_pi.size() > 65535) ? 65535 : win_pi.size();
      m_valid = 1;
    end else if (xfer) begin
      m_valid = 0;
    end
    if (!run) begin
      m_in_win = 0;
      win_pi.delete(); win_pq.delete();
    end else if (!m_in_win) begin
      if (win_stb) m_in_win = 1;
    end else begin
      if (win_stb) begin
        win_pi.delete(); win_pq.delete();
      end
      if (sample_valid) begin
        win_pi.push_back((sample_in == ref_i) ? 1 : -1);
        win_pq.push_back((sample_in == ref_q) ? 1 : -1);
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid16", int'(v16), int'(m_valid));
    check("out_i16", int'(i16), m_i16);
    check("out_q16", int'(q16), m_q16);
    check("out_cnt16", int'(c16), m_cnt);
    check("overrun16", int'(ovr16), int'(m_ovr));
    check("out_valid8", int'(v8), int'(m_valid));
    check("out_i8", int'(i8), m_i8);
    check("out_q8", int'(q8), m_q8);
    check("out_cnt8", int'(c8), m_cnt);
    check("overrun8", int'(ovr8), int'(m_ovr));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_in(input bit r, input bit w, input bit sv, input bit s,
                        input bit ri, input bit rq, input bit rdy);
    run = r; win_stb = w; sample_valid = sv; sample_in = s;
    ref_i = ri; ref_q = rq; out_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  // I matches the sample, Q is its complement.
  task automatic feed(input int n, input bit rdy);
    bit s;
    for (int k = 0; k < n; k++) begin
      s = 1'($urandom);
      set_in(1, 0, 1, s, s, ~s, rdy);
      tick();
    end
  endtask

  task automatic start_window(input bit rdy);
    set_in(1, 1, 0, 0, 0, 0, rdy);
    tick();
  endtask

  typedef struct {
    bit r, w, sv, s, ri, rq, rdy;
    bit e_valid;
    int e_i, e_q, e_cnt;
    bit e_ovr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 1, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 1, 1, 0, 0,  0,  0, 0, 0, 0};
    vecs[2] = '{1, 0, 1, 0, 0, 0, 0,  0,  0, 0, 0, 0};
    vecs[3] = '{1, 1, 1, 1, 0, 1, 0,  1,  2, 0, 2, 0};
    vecs[4] = '{1, 1, 0, 0, 0, 0, 0,  1, -1, 1, 1, 1};
    vecs[5] = '{1, 1, 0, 0, 0, 0, 1,  1,  0, 0, 0, 1};
    vecs[6] = '{1, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0, 1};
    vecs[7] = '{0, 1, 1, 1, 1, 1, 0,  0,  0, 0, 0, 1};
    vecs[8] = '{1, 1, 1, 1, 1, 1, 0,  0,  0, 0, 0, 1};
    vecs[9] = '{1, 1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 1};

    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    do_reset();

    // Table vectors
    for (int k = 0; k < 10; k++) begin
      set_in(vecs[k].r, vecs[k].w, vecs[k].sv, vecs[k].s, vecs[k].ri, vecs[k].rq, vecs[k].rdy);
      tick();
      check("tbl_valid", int'(v16), int'(vecs[k].e_valid));
      check("tbl_i", int'(i16), vecs[k].e_i);
      check("tbl_q", int'(q16), vecs[k].e_q);
      check("tbl_cnt", int'(c16), vecs[k].e_cnt);
      check("tbl_ovr", int'(ovr16), int'(vecs[k].e_ovr));
      $display("vec %0d: valid=%0d i=%0d q=%0d cnt=%0d ovr=%0d", k, v16, i16, q16, c16, ovr16);
    end

    // Full 2048-sample window; 8-bit instance saturates
    do_reset();
    start_window(0);
    feed(2048, 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    check("pre_dump_valid", int'(v16), 0);
    tick();
    check("w2048_valid", int'(v16), 1);
    check("w2048_i", int'(i16), 2048);
    check("w2048_q", int'(q16), -2048);
    check("w2048_cnt", int'(c16), 2048);
    check("w2048_i8_sat", int'(i8), 127);
    check("w2048_q8_sat", int'(q8), -127);
    $display("dump2048: i=%0d q=%0d cnt=%0d i8=%0d q8=%0d", i16, q16, c16, i8, q8);

    // Strobe coincident with a sample: sample goes to the new window
    feed(3, 1);
    set_in(1, 1, 1, 1, 1, 1, 1);
    tick();
    check("coinc_i", int'(i16), 3);
    check("coinc_cnt", int'(c16), 3);
    set_in(1, 1, 0, 0, 0, 0, 1);
    tick();
    check("next_i", int'(i16), 1);
    check("next_q", int'(q16), 1);
    check("next_cnt", int'(c16), 1);

    // Overrun: two dumps without readout
    do_reset();
    start_window(0);
    feed(10, 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    tick();
    feed(20, 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    tick();
    check("ovr_i", int'(i16), 20);
    check("ovr_flag", int'(ovr16), 1);
    check("ovr_valid", int'(v16), 1);
    set_in(1, 0, 0, 0, 0, 0, 1);
    tick();
    check("ovr_drain_valid", int'(v16), 0);
    check("ovr_sticky", int'(ovr16), 1);

    // Readout and dump in the same cycle
    do_reset();
    start_window(0);
    feed(5, 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    tick();
    feed(7, 0);
    set_in(1, 1, 0, 0, 0, 0, 1);
    tick();
    check("simul_i", int'(i16), 7);
    check("simul_cnt", int'(c16), 7);
    check("simul_valid", int'(v16), 1);
    check("simul_ovr", int'(ovr16), 0);

    // run drop discards the partial window; then async reset mid-window
    do_reset();
    start_window(0);
    feed(100, 0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick();
    start_window(0);
    feed(5, 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    tick();
    check("partial_cnt", int'(c16), 5);
    check("partial_i", int'(i16), 5);
    feed(3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(v16), 0);
    check("arst_i", int'(i16), 0);
    check("arst_q", int'(q16), 0);
    check("arst_cnt", int'(c16), 0);
    check("arst_ovr", int'(ovr16), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic: short windows, then long biased windows
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      set_in($urandom_range(0, 99) < 96, $urandom_range(0, 11) == 0,
             $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
      tick();
    end
    for (int k = 0; k < 3000; k++) begin
      bit s;
      s = 1'($urandom);
      set_in($urandom_range(0, 999) < 998, $urandom_range(0, 249) == 0,
             $urandom_range(0, 9) < 8, s,
             ($urandom_range(0, 9) < 9) ? s : ~s,
             ($urandom_range(0, 9) < 9) ? ~s : s,
             $urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
